// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module : lsu_pkg
// Desc   : Shared funct3 encodings, LSU state type and access-check helpers.
// Rev    : 1.0  initial release
// ============================================================================
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    MERGE_WR = 2'd2,
    RESP     = 2'd3
  } lsu_state_t;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    case (funct3)
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Unsigned widths only exist for loads; the remaining encodings are unused.
  function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
    logic ill;
    case (funct3)
      F3_B, F3_H, F3_W: ill = 1'b0;
      F3_BU, F3_HU:     ill = we;
      default:          ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane.sv
`default_nettype none
// ============================================================================
// Module : lsu_lane
// Desc   : Byte/half lane extraction with sign/zero extension, and sub-word
//          store merge into a previously read word (little-endian lanes).
// Rev    : 1.0  initial release
// ============================================================================
module lsu_lane
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] ld_word,
  input  logic [XLEN-1:0] mg_word,
  input  logic [1:0]      off,
  input  logic [15:0]     st_data,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] ld_data,
  output logic [XLEN-1:0] mg_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (off)
      2'd0:    w_byte = ld_word[7:0];
      2'd1:    w_byte = ld_word[15:8];
      2'd2:    w_byte = ld_word[23:16];
      default: w_byte = ld_word[31:24];
    endcase
    w_half = off[1] ? ld_word[31:16] : ld_word[15:0];

    case (funct3)
      F3_B:    ld_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_BU:   ld_data = {{(XLEN-8){1'b0}}, w_byte};
      F3_H:    ld_data = {{(XLEN-16){w_half[15]}}, w_half};
      F3_HU:   ld_data = {{(XLEN-16){1'b0}}, w_half};
      F3_W:    ld_data = ld_word;
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    mg_data = mg_word;
    if (funct3 == F3_B) begin
      case (off)
        2'd0:    mg_data[7:0]   = st_data[7:0];
        2'd1:    mg_data[15:8]  = st_data[7:0];
        2'd2:    mg_data[23:16] = st_data[7:0];
        default: mg_data[31:24] = st_data[7:0];
      endcase
    end else if (funct3 == F3_H) begin
      if (off[1]) mg_data[31:16] = st_data;
      else        mg_data[15:0]  = st_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module : load_store_unit
// Desc   : Data-memory initiator; sub-word stores are read-modify-write.
//          Optional LSU_STATS_EN adds ld_cnt/st_cnt/err_cnt completion counters.
// Rev    : 1.0  initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 6,
  parameter int XLEN   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic            we,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] rdata,
  output logic            err,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
`ifdef LSU_STATS_EN
  ,
  output logic [31:0]     ld_cnt,
  output logic [31:0]     st_cnt,
  output logic [31:0]     err_cnt
`endif
);

  lsu_state_t      r_state, w_state_nxt;
  logic            r_we, r_err;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_addr, r_wdata, r_merge, r_rdata;
  logic [XLEN-1:0] w_ld_data, w_mg_data, w_word_addr;
  logic            w_bad;

  assign w_bad       = is_misaligned(funct3, addr[1:0]) | is_illegal(we, funct3);
  assign w_word_addr = {{(XLEN-MEM_AW){1'b0}}, r_addr[MEM_AW+1:2]};
  assign rdata       = r_rdata;

  lsu_lane #(.XLEN(XLEN)) u_lane (
    .ld_word (mem_rdata),
    .mg_word (r_merge),
    .off     (r_addr[1:0]),
    .st_data (r_wdata[15:0]),
    .funct3  (r_funct3),
    .ld_data (w_ld_data),
    .mg_data (w_mg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Write strobes are masked by rst so an abort never lands a partial write.
  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (req) w_state_nxt = w_bad ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_addr = w_word_addr;
        if (!r_we) begin
          w_state_nxt = RESP;
        end else if (r_funct3 == F3_W) begin
          mem_we      = ~rst;
          mem_wdata   = rst ? '0 : r_wdata;
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = MERGE_WR;
        end
      end
      MERGE_WR: begin
        mem_addr    = w_word_addr;
        mem_we      = ~rst;
        mem_wdata   = rst ? '0 : w_mg_data;
        w_state_nxt = RESP;
      end
      RESP: begin
        done        = 1'b1;
        err         = r_err;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_merge  <= '0;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req) begin
            r_we     <= we;
            r_funct3 <= funct3;
            r_addr   <= addr;
            r_wdata  <= wdata;
            r_err    <= w_bad;
            if (w_bad) r_rdata <= '0;
          end
        end
        ACCESS: begin
          if (!r_we)                  r_rdata <= w_ld_data;
          else if (r_funct3 != F3_W)  r_merge <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

`ifdef LSU_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt  <= '0;
      st_cnt  <= '0;
      err_cnt <= '0;
    end else if (done) begin
      if (r_err)     err_cnt <= err_cnt + 32'd1;
      else if (r_we) st_cnt  <= st_cnt + 32'd1;
      else           ld_cnt  <= ld_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_load_store_unit
// Desc   : Directed scoreboard bench for load_store_unit with a word memory.
// Rev    : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk, rst, req, we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  logic        ready, done, err, mem_we;
`ifdef LSU_STATS_EN
  logic [31:0] ld_cnt, st_cnt, err_cnt;
`endif

  load_store_unit #(.MEM_AW(6), .XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef LSU_STATS_EN
    ,
    .ld_cnt    (ld_cnt),
    .st_cnt    (st_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory with same-cycle read
  logic [31:0] mem [64];
  logic        preload;
  assign mem_rdata = mem[mem_addr[5:0]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= i;
    end else if (mem_we) begin
      mem[mem_addr[5:0]] <= mem_wdata;
    end
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        chk_rd;
    logic [31:0] acc;
    logic [3:0]  lat;
  } ent_t;

  ent_t        sb[$];
  string       sb_tag[$];
  logic [31:0] ref_mem [64];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          n_done = 0;
  int          we_cnt = 0;
  int          overlap = 0;
  logic [31:0] last_wd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic ent_t model(input logic w, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd);
    ent_t        e;
    logic [31:0] word, tmp, mask;
    logic        bad;
    int          sh;
    word = ref_mem[a[7:2]];
    sh   = 8 * int'(a[1:0]);
    bad  = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (w && f3[2]) ||
           ((f3[1:0] == 2'b01) && a[0]) || ((f3 == 3'b010) && (a[1:0] != 2'b00));
    e        = '0;
    e.err    = bad;
    e.chk_rd = !w || bad;
    if (bad)                e.lat = 4'd1;
    else if (!w)            e.lat = 4'd2;
    else if (f3 == 3'b010)  e.lat = 4'd2;
    else                    e.lat = 4'd3;
    if (!bad && !w) begin
      tmp = word >> sh;
      case (f3)
        3'b000:  e.rdata = {{24{tmp[7]}}, tmp[7:0]};
        3'b100:  e.rdata = {24'h0, tmp[7:0]};
        3'b001:  e.rdata = {{16{tmp[15]}}, tmp[15:0]};
        3'b101:  e.rdata = {16'h0, tmp[15:0]};
        default: e.rdata = word;
      endcase
    end
    if (!bad && w) begin
      mask = (f3 == 3'b000) ? 32'hFF : (f3 == 3'b001) ? 32'hFFFF : 32'hFFFF_FFFF;
      ref_mem[a[7:2]] = (word & ~(mask << sh)) | ((wd & mask) << sh);
    end
    return e;
  endfunction

  // One negedge sample: retire a completion against the scoreboard
  task automatic tick();
    ent_t  e;
    string t;
    @(negedge clk);
    cyc++;
    if (mem_we) begin
      we_cnt++;
      last_wd = mem_wdata;
    end
    if (ready && done) overlap++;
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        t = sb_tag.pop_front();
        chk($sformatf("%s_lat", t), cyc - e.acc, {28'h0, e.lat});
        chk($sformatf("%s_err", t), {31'h0, err}, {31'h0, e.err});
        if (e.chk_rd) chk($sformatf("%s_rdata", t), rdata, e.rdata);
      end
    end
  endtask

  task automatic do_req(input string tag, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    ent_t e;
    int   n, d0;
    n = 0;
    while (!ready && n < 20) begin tick(); n++; end
    chk($sformatf("%s_ready", tag), {31'h0, ready}, 32'd1);
    e     = model(w, f3, a, wd);
    e.acc = cyc;
    sb.push_back(e);
    sb_tag.push_back(tag);
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
    we_cnt = 0;
    d0 = n_done;
    @(posedge clk);
    tick();
    req = 1'b0;
    n = 0;
    while (n_done == d0 && n < 10) begin tick(); n++; end
    chk($sformatf("%s_done", tag), n_done - d0, 32'd1);
    chk($sformatf("%s_wecnt", tag), we_cnt, (w && !e.err) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int   n, d0;
    ent_t e;
    rst = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
    preload = 1'b1;
    for (int i = 0; i < 64; i++) ref_mem[i] = i;
    tick();
    tick();
    chk("rst_ready", {31'h0, ready}, 32'd1);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_err", {31'h0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0; preload = 1'b0;
    tick();

    do_req("lw14", 1'b0, 3'b010, 32'h14, 32'h0);
    do_req("sw20", 1'b1, 3'b010, 32'h20, 32'hDEADBEEF);
    do_req("lb23", 1'b0, 3'b000, 32'h23, 32'h0);
    do_req("lbu21", 1'b0, 3'b100, 32'h21, 32'h0);
    do_req("lh22", 1'b0, 3'b001, 32'h22, 32'h0);
    do_req("lhu20", 1'b0, 3'b101, 32'h20, 32'h0);
    do_req("sb21", 1'b1, 3'b000, 32'h21, 32'h55);
    chk("sb21_wdata", last_wd, 32'hDEAD55EF);
    do_req("lw20", 1'b0, 3'b010, 32'h20, 32'h0);
    do_req("sh2e", 1'b1, 3'b001, 32'h2E, 32'hAAAA9876);
    do_req("lw2c", 1'b0, 3'b010, 32'h2C, 32'h0);

    do_req("err_lw06", 1'b0, 3'b010, 32'h06, 32'h0);
    do_req("err_sh03", 1'b1, 3'b001, 32'h03, 32'h1111);
    do_req("err_f3_011", 1'b0, 3'b011, 32'h00, 32'h0);
    do_req("err_sbu", 1'b1, 3'b100, 32'h04, 32'h22);

    // Reset while in MERGE_WR must abort the write
    n = 0;
    while (!ready && n < 20) begin tick(); n++; end
    req = 1'b1; we = 1'b1; funct3 = 3'b001; addr = 32'h22; wdata = 32'h1234;
    @(posedge clk);
    tick();
    req = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("abort_mem_we", {31'h0, mem_we}, 32'd0);
    chk("abort_mem_wdata", mem_wdata, 32'd0);
    tick();
    chk("abort_ready", {31'h0, ready}, 32'd1);
    chk("abort_done", {31'h0, done}, 32'd0);
    chk("abort_err", {31'h0, err}, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    tick();
    do_req("lw20_post", 1'b0, 3'b010, 32'h20, 32'h0);

    // Back-to-back loads with req held high
    d0 = n_done;
    overlap = 0;
    we_cnt = 0;
    req = 1'b1; we = 1'b0; funct3 = 3'b010;
    for (int i = 1; i <= 3; i++) begin
      n = 0;
      while (!ready && n < 20) begin tick(); n++; end
      addr  = 32'(i * 4);
      e     = model(1'b0, 3'b010, addr, 32'h0);
      e.acc = cyc;
      sb.push_back(e);
      sb_tag.push_back($sformatf("b2b%0d", i));
      @(posedge clk);
      tick();
    end
    req = 1'b0;
    n = 0;
    while (n_done - d0 < 3 && n < 20) begin tick(); n++; end
    repeat (4) tick();
    chk("b2b_done_count", n_done - d0, 32'd3);
    chk("b2b_ready_done_overlap", overlap, 32'd0);
    chk("b2b_wecnt", we_cnt, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
